// File: rtl/jb_srx_pkg.sv
// ---------------------------------------------------------------------------
// jb_srx_pkg
// Shared definitions for the SRX observation scheduler:
//   - request-type codes carried in control-request tdata[7:4]
//   - ACK_HOLDOFF: WAIT_ACK cycles during which the grant field is ignored
//   - sched_state_t: scheduler FSM encoding (also exported as a debug port)
//   - make_req(): packs a control request byte {type, 1'b0, antenna}
// ---------------------------------------------------------------------------
package jb_srx_pkg;

  localparam logic [3:0] REQ_DPD   = 4'h0;
  localparam logic [3:0] REQ_HIRES = 4'h1;
  localparam logic [3:0] REQ_VSWR  = 4'h2;
  localparam logic [3:0] REQ_AVAIL = 4'hF;

  // The antenna mux needs a few cycles after a request before its grant
  // field is trustworthy; a stale grant naming the same antenna must not
  // start a dwell early.
  localparam int ACK_HOLDOFF = 4;

  localparam int ANT_W = 3;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SELECT   = 3'd1,
    ST_REQUEST  = 3'd2,
    ST_WAIT_ACK = 3'd3,
    ST_DWELL    = 3'd4,
    ST_RELEASE  = 3'd5
  } sched_state_t;

  function automatic logic [7:0] make_req(input logic [3:0]       rtype,
                                          input logic [ANT_W-1:0] ant);
    return {rtype, 1'b0, ant};
  endfunction

endpackage

// File: rtl/jb_srx_obs_sched_if.sv
// ---------------------------------------------------------------------------
// jb_srx_obs_sched_if
// Stream bundle for the observation scheduler.
//   m_ctrl_* : 8-bit control request to the antenna mux, {type, 0, ant}
//   s_srx_*  : SRX sample stream, tdata = {Q[31:16], I[15:0]},
//              tuser[2:0] = antenna currently granted by the mux
//   obs_*    : captured dwell samples, obs_tlast on the final dwell beat
// Modports: master = scheduler side, slave = environment side.
//
// Handshake: a transfer happens on a rising edge where tvalid and tready
// are both 1. Once tvalid is raised, tvalid and tdata stay constant until
// that transfer. tready may be driven independently of tvalid.
// The SRX stream is never stalled (s_srx_tready is always 1) and the obs
// stream has no ready, so the consumer must accept every beat.
// ---------------------------------------------------------------------------
interface jb_srx_obs_sched_if;

  logic        m_ctrl_tvalid;
  logic        m_ctrl_tready;
  logic [7:0]  m_ctrl_tdata;

  logic [31:0] s_srx_tdata;
  logic        s_srx_tvalid;
  logic [7:0]  s_srx_tuser;
  logic        s_srx_tready;

  logic [31:0] obs_tdata;
  logic        obs_tvalid;
  logic        obs_tlast;
  logic [2:0]  obs_ant;

  modport master (
    output m_ctrl_tvalid, m_ctrl_tdata,
    input  m_ctrl_tready,
    input  s_srx_tdata, s_srx_tvalid, s_srx_tuser,
    output s_srx_tready,
    output obs_tdata, obs_tvalid, obs_tlast, obs_ant
  );

  modport slave (
    input  m_ctrl_tvalid, m_ctrl_tdata,
    output m_ctrl_tready,
    output s_srx_tdata, s_srx_tvalid, s_srx_tuser,
    input  s_srx_tready,
    input  obs_tdata, obs_tvalid, obs_tlast, obs_ant
  );

endinterface

// File: rtl/jb_rr_mask_sel.sv
// ---------------------------------------------------------------------------
// jb_rr_mask_sel
// Combinational round-robin pick from an antenna mask.
//   mask       : candidate antennas
//   cur        : antenna served last
//   from_start : 1 = search begins at antenna 0 inclusive (start of a pass)
//                0 = search begins strictly above cur
//   sel        : chosen antenna (lowest set bit when the search wrapped)
//   wrapped    : no candidate at/above the start point, the pick wrapped
//   any_set    : mask is non-zero
// ---------------------------------------------------------------------------
module jb_rr_mask_sel #(
  parameter int N = 4
) (
  input  logic [N-1:0] mask,
  input  logic [2:0]   cur,
  input  logic         from_start,
  output logic [2:0]   sel,
  output logic         wrapped,
  output logic         any_set
);

  logic [2:0] lowest;
  logic [2:0] above;
  logic       above_hit;

  always_comb begin
    lowest    = '0;
    above     = '0;
    above_hit = 1'b0;
    // Walk downward so the final assignment is the lowest qualifying index.
    for (int i = N - 1; i >= 0; i--) begin
      if (mask[i]) begin
        lowest = 3'(i);
        if (from_start || (3'(i) > cur)) begin
          above     = 3'(i);
          above_hit = 1'b1;
        end
      end
    end
  end

  assign any_set = |mask;
  assign sel     = above_hit ? above : lowest;
  assign wrapped = any_set && !above_hit;

endmodule

// File: rtl/jb_srx_obs_sched.sv
// ---------------------------------------------------------------------------
// jb_srx_obs_sched
// Schedules SRX observation captures across a set of antennas. For each
// antenna in ant_mask it requests the antenna mux, waits for the grant on
// the SRX stream, forwards dwell_len samples to the obs stream and moves on.
// After the last antenna of a pass it releases the mux (AVAIL request) and
// pulses scan_done.
//
// Ports:
//   axis_aclk, axis_areset : clock, synchronous active-high reset
//   enable                 : run scan passes
//   ant_mask               : antennas included in the scan
//   req_type               : request type for capture requests
//   dwell_len              : samples per antenna (0 behaves as 1)
//   ack_timeout            : cycles allowed in WAIT_ACK before skipping
//   bus                    : control / SRX / obs streams (master modport)
//   busy                   : FSM not in IDLE
//   scan_done              : one-cycle pulse after the release is accepted
//   timeout_err            : sticky; cleared by reset or rising enable
//   state_dbg              : current FSM state
// ---------------------------------------------------------------------------
module jb_srx_obs_sched
  import jb_srx_pkg::*;
#(
  parameter int N_ANTENNAS = 4,
  parameter int CNT_W      = 16
) (
  input  logic                  axis_aclk,
  input  logic                  axis_areset,
  input  logic                  enable,
  input  logic [N_ANTENNAS-1:0] ant_mask,
  input  logic [3:0]            req_type,
  input  logic [CNT_W-1:0]      dwell_len,
  input  logic [CNT_W-1:0]      ack_timeout,
  jb_srx_obs_sched_if.master    bus,
  output logic                  busy,
  output logic                  scan_done,
  output logic                  timeout_err,
  output sched_state_t          state_dbg
);

  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W:0]   CNT_ONE_X = (CNT_W + 1)'(1);
  localparam logic [CNT_W-1:0] HOLDOFF_C = CNT_W'(ACK_HOLDOFF);

  sched_state_t state, state_n;

  logic [2:0]       cur_ant;
  logic             from_start;
  logic [3:0]       req_q;
  logic [CNT_W-1:0] dwell_q;
  logic [CNT_W-1:0] tmo_q;
  logic [CNT_W-1:0] wait_cnt;
  logic [CNT_W-1:0] beat_cnt;
  logic             en_d;

  logic [31:0]      obs_tdata_q;
  logic             obs_tvalid_q;
  logic             obs_tlast_q;
  logic [2:0]       obs_ant_q;
  logic             scan_done_q;
  logic             timeout_err_q;

  logic             ctrl_valid;
  logic [7:0]       ctrl_data;

  logic [2:0]       rr_sel;
  logic             rr_wrapped;
  logic             rr_any;

  logic             ack_match;
  logic             ack_tmo;
  logic             last_beat;
  logic             ctrl_fire;
  logic             sel_go;
  logic             unused_tuser;

  jb_rr_mask_sel #(
    .N (N_ANTENNAS)
  ) u_rr_sel (
    .mask       (ant_mask),
    .cur        (cur_ant),
    .from_start (from_start),
    .sel        (rr_sel),
    .wrapped    (rr_wrapped),
    .any_set    (rr_any)
  );

  // Grant is only trusted once the holdoff has elapsed.
  assign ack_match = (wait_cnt >= HOLDOFF_C) &&
                     (bus.s_srx_tuser[2:0] == cur_ant);
  // wait_cnt is the index of the current WAIT_ACK cycle, so wait_cnt+1
  // cycles have been spent once this one ends; WAIT_ACK therefore lasts
  // exactly ack_timeout cycles (at least one) before giving up.
  assign ack_tmo   = ({1'b0, wait_cnt} + CNT_ONE_X) >= {1'b0, tmo_q};
  assign last_beat = (beat_cnt == (dwell_q - CNT_ONE));
  assign ctrl_fire = ctrl_valid && bus.m_ctrl_tready;
  // A new antenna is only started while enabled; otherwise the pass ends.
  assign sel_go    = enable && rr_any && !rr_wrapped;

  assign unused_tuser = ^bus.s_srx_tuser[7:3];

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge axis_aclk) begin
    if (axis_areset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n    = state;
    ctrl_valid = 1'b0;
    ctrl_data  = '0;
    unique case (state)
      ST_IDLE: begin
        if (enable && rr_any) state_n = ST_SELECT;
      end
      ST_SELECT: begin
        state_n = sel_go ? ST_REQUEST : ST_RELEASE;
      end
      ST_REQUEST: begin
        ctrl_valid = 1'b1;
        ctrl_data  = make_req(req_q, cur_ant);
        if (bus.m_ctrl_tready) state_n = ST_WAIT_ACK;
      end
      ST_WAIT_ACK: begin
        // Match wins over a simultaneous timeout.
        if (ack_match)    state_n = ST_DWELL;
        else if (ack_tmo) state_n = ST_SELECT;
      end
      ST_DWELL: begin
        if (bus.s_srx_tvalid && last_beat) begin
          state_n = enable ? ST_SELECT : ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        ctrl_valid = 1'b1;
        ctrl_data  = make_req(REQ_AVAIL, cur_ant);
        if (bus.m_ctrl_tready) begin
          state_n = (enable && rr_any) ? ST_SELECT : ST_IDLE;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // ----------------------------------------------------------- datapath
  always_ff @(posedge axis_aclk) begin
    if (axis_areset) begin
      cur_ant       <= '0;
      from_start    <= 1'b1;
      req_q         <= '0;
      dwell_q       <= '0;
      tmo_q         <= '0;
      wait_cnt      <= '0;
      beat_cnt      <= '0;
      en_d          <= 1'b0;
      obs_tdata_q   <= '0;
      obs_tvalid_q  <= 1'b0;
      obs_tlast_q   <= 1'b0;
      obs_ant_q     <= '0;
      scan_done_q   <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      en_d         <= enable;
      obs_tvalid_q <= 1'b0;
      obs_tlast_q  <= 1'b0;
      scan_done_q  <= 1'b0;

      if (enable && !en_d) timeout_err_q <= 1'b0;

      unique case (state)
        ST_IDLE: begin
          from_start <= 1'b1;
        end
        ST_SELECT: begin
          // Per-antenna settings are frozen here for the whole visit.
          req_q   <= req_type;
          dwell_q <= (dwell_len == '0) ? CNT_ONE : dwell_len;
          tmo_q   <= ack_timeout;
          if (sel_go) begin
            cur_ant    <= rr_sel;
            from_start <= 1'b0;
          end
        end
        ST_REQUEST: begin
          wait_cnt <= '0;
        end
        ST_WAIT_ACK: begin
          wait_cnt <= wait_cnt + CNT_ONE;
          beat_cnt <= '0;
          if (!ack_match && ack_tmo) timeout_err_q <= 1'b1;
        end
        ST_DWELL: begin
          if (bus.s_srx_tvalid) begin
            obs_tdata_q  <= bus.s_srx_tdata;
            obs_tvalid_q <= 1'b1;
            obs_tlast_q  <= last_beat;
            obs_ant_q    <= cur_ant;
            beat_cnt     <= beat_cnt + CNT_ONE;
          end
        end
        ST_RELEASE: begin
          if (ctrl_fire) begin
            scan_done_q <= 1'b1;
            from_start  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // ------------------------------------------------------------ outputs
  assign bus.m_ctrl_tvalid = ctrl_valid;
  assign bus.m_ctrl_tdata  = ctrl_data;
  assign bus.s_srx_tready  = 1'b1;
  assign bus.obs_tdata     = obs_tdata_q;
  assign bus.obs_tvalid    = obs_tvalid_q;
  assign bus.obs_tlast     = obs_tlast_q;
  assign bus.obs_ant       = obs_ant_q;

  assign busy        = (state != ST_IDLE);
  assign scan_done   = scan_done_q;
  assign timeout_err = timeout_err_q;
  assign state_dbg   = state;

endmodule
